// File: rtl/init_safe_tx.sv
// init_safe_tx: MSB-first serial transmitter with fully registered outputs and a post-reset hold-off.
// Define INIT_SAFE_TX_PARITY_EN to append an even-parity bit after data bit 0.
module init_safe_tx #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned STARTUP_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             ser_out,
    output logic             frame_out,
    output logic             busy
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned SW = $clog2(STARTUP_CYCLES + 1);
    localparam logic [BW-1:0] BitLast   = BW'(WIDTH - 1);
    localparam logic [SW-1:0] StartLast = SW'(STARTUP_CYCLES - 1);
    localparam logic [SW-1:0] StartMax  = SW'(STARTUP_CYCLES);

    typedef enum logic [1:0] {StStartup, StIdle, StShift, StParity} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             ready_q, ready_d;
    logic             ser_q, ser_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
`ifdef INIT_SAFE_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        ready_d = ready_q;
        ser_d   = ser_q;
        frame_d = frame_q;
        busy_d  = busy_q;
`ifdef INIT_SAFE_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StStartup: begin
                if (scnt_q == StartLast) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else if (scnt_q != StartMax) begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            StIdle: begin
                if (valid_in && ready_q) begin
                    state_d = StShift;
                    shreg_d = data_in;
                    bcnt_d  = BitLast;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    frame_d = 1'b1;
                    ser_d   = data_in[WIDTH-1];
`ifdef INIT_SAFE_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            StShift: begin
                // bcnt_q is the index of the bit currently on ser_out
                if (bcnt_q != '0) begin
                    ser_d   = shreg_q[WIDTH-2];
                    shreg_d = shreg_q << 1;
                    bcnt_d  = bcnt_q - BW'(1);
                end else begin
`ifdef INIT_SAFE_TX_PARITY_EN
                    state_d = StParity;
                    ser_d   = par_q;
`else
                    state_d = StIdle;
                    frame_d = 1'b0;
                    ser_d   = 1'b0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
`endif
                end
            end
            StParity: begin
                state_d = StIdle;
                frame_d = 1'b0;
                ser_d   = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StStartup;
            scnt_q  <= '0;
            shreg_q <= '0;
            bcnt_q  <= '0;
            ready_q <= 1'b0;
            ser_q   <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef INIT_SAFE_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            ready_q <= ready_d;
            ser_q   <= ser_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
`ifdef INIT_SAFE_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ready_out = ready_q;
    assign ser_out   = ser_q;
    assign frame_out = frame_q;
    assign busy      = busy_q;

endmodule
